// File: rtl/regs_wb_arbiter_if.sv
// Writeback arbiter bus: two requester handshakes, register-file write port,
// pending-write lookup and status.
interface regs_wb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              flush;
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic              busy;

  // Arbiter side
  modport slave (
    input  flush, a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, q_hit, busy
  );

  // Requester / decode / register-file side
  modport master (
    output flush, a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, q_hit, busy
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Two-requester writeback arbiter: per-requester FIFOs drained round-robin
// into a registered register-file write port, with pending-address lookup.
module regs_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic      clk,
  input logic      rst_n,
  regs_wb_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREQ  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Index 0 is requester A, index 1 is requester B.
  wb_entry_t        mem      [NREQ][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr   [NREQ];
  logic [PTR_W-1:0] wr_ptr   [NREQ];
  logic [CNT_W-1:0] cnt      [NREQ];
  wb_entry_t        in_entry [NREQ];
  wb_entry_t        head     [NREQ];

  logic [NREQ-1:0] in_valid;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] nonempty;
  logic [NREQ-1:0] full;

  logic              last_b;
  logic              grant_a;
  logic              grant_b;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              hit;

  // FIFO status, handshake and enqueue qualification (r0 writes are swallowed)
  always_comb begin
    in_valid    = {bus.b_valid, bus.a_valid};
    in_entry[0] = '{addr: bus.a_addr, data: bus.a_data};
    in_entry[1] = '{addr: bus.b_addr, data: bus.b_data};
    ready       = '0;
    push        = '0;
    nonempty    = '0;
    full        = '0;
    for (int r = 0; r < NREQ; r++) begin
      nonempty[r] = (cnt[r] != '0);
      full[r]     = (cnt[r] == CNT_W'(FIFO_DEPTH));
      ready[r]    = rst_n & ~full[r] & ~bus.flush;
      push[r]     = in_valid[r] & ready[r] & (in_entry[r].addr != '0);
      head[r]     = mem[r][rd_ptr[r]];
    end
  end

  // Round-robin grant on FIFO heads; the requester not served last wins a tie
  always_comb begin
    grant_a = ~bus.flush & nonempty[0] & (~nonempty[1] | last_b);
    grant_b = ~bus.flush & nonempty[1] & (~nonempty[0] | ~last_b);
    pop     = {grant_b, grant_a};
  end

  // FIFO pointers and occupancy; flush drops everything still queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREQ; r++) begin
        rd_ptr[r] <= '0;
        wr_ptr[r] <= '0;
        cnt[r]    <= '0;
      end
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        if (bus.flush) begin
          rd_ptr[r] <= '0;
          wr_ptr[r] <= '0;
          cnt[r]    <= '0;
        end else begin
          if (push[r]) wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
          if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
          cnt[r] <= cnt[r] + CNT_W'(push[r]) - CNT_W'(pop[r]);
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (push[r]) mem[r][wr_ptr[r]] <= in_entry[r];
    end
  end

  // Round-robin history; reset value lets A win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end

  // Registered write port: one-cycle enable pulse per grant, address/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (grant_a) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= head[0].addr;
      rf_wdata_q <= head[0].data;
    end else if (grant_b) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= head[1].addr;
      rf_wdata_q <= head[1].data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  // Pending-write lookup over live FIFO slots and the write in flight; r0 never hits
  always_comb begin
    logic [PTR_W-1:0] offs;
    offs = '0;
    hit  = 1'b0;
    if (bus.q_addr != '0) begin
      hit = rf_we_q & (rf_waddr_q == bus.q_addr);
      for (int r = 0; r < NREQ; r++) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          offs = PTR_W'(i) - rd_ptr[r];
          if ((CNT_W'(offs) < cnt[r]) && (mem[r][i].addr == bus.q_addr)) hit = 1'b1;
        end
      end
    end
  end

  assign bus.a_ready  = ready[0];
  assign bus.b_ready  = ready[1];
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.q_hit    = hit;
  assign bus.busy     = (|nonempty) | rf_we_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter. Requester A uses addresses 1..15,
// requester B uses 16..31, so each write's source is its address MSB.
module tb_regs_wb_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W+DATA_W-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regs_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regs_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  ent_t              exp_a[$];
  ent_t              exp_b[$];
  bit                src_log[$];
  logic              rdy_log[$];
  logic [ADDR_W-1:0] sa_addr[$];
  logic [ADDR_W-1:0] sb_addr[$];
  logic [DATA_W-1:0] sa_data[$];
  logic [DATA_W-1:0] sb_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: retire writes seen on the port, then record accepted inputs
  always @(negedge clk) begin : mon
    ent_t got;
    ent_t want;
    if (rst_n) begin
      if (bus.rf_we === 1'b1) begin
        got = {bus.rf_waddr, bus.rf_wdata};
        if (bus.rf_waddr[ADDR_W-1]) begin
          check("sb_b_pending", 64'(exp_b.size() != 0), 1);
          if (exp_b.size() != 0) begin
            want = exp_b.pop_front();
            check("sb_b_write", 64'(got), 64'(want));
          end
          src_log.push_back(1'b1);
        end else begin
          check("sb_a_pending", 64'(exp_a.size() != 0), 1);
          if (exp_a.size() != 0) begin
            want = exp_a.pop_front();
            check("sb_a_write", 64'(got), 64'(want));
          end
          src_log.push_back(1'b0);
        end
      end
      if (bus.flush) begin
        exp_a.delete();
        exp_b.delete();
      end else begin
        if (bus.a_valid && bus.a_ready && bus.a_addr != '0) exp_a.push_back({bus.a_addr, bus.a_data});
        if (bus.b_valid && bus.b_ready && bus.b_addr != '0) exp_b.push_back({bus.b_addr, bus.b_data});
      end
    end
  end

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_addr  = '0;
    bus.b_addr  = '0;
    bus.a_data  = '0;
    bus.b_data  = '0;
    bus.flush   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_a.delete();
    exp_b.delete();
    src_log.delete();
  endtask

  // Drive both stimulus queues, holding each item until it is accepted
  task automatic run_streams(input int max_cyc);
    int ia = 0;
    int ib = 0;
    int cyc = 0;
    bit ta;
    bit tb_;
    rdy_log.delete();
    while ((ia < sa_addr.size() || ib < sb_addr.size()) && cyc < max_cyc) begin
      bus.a_valid = (ia < sa_addr.size());
      if (bus.a_valid) begin bus.a_addr = sa_addr[ia]; bus.a_data = sa_data[ia]; end
      bus.b_valid = (ib < sb_addr.size());
      if (bus.b_valid) begin bus.b_addr = sb_addr[ib]; bus.b_data = sb_data[ib]; end
      @(negedge clk);
      rdy_log.push_back(bus.a_ready);
      ta  = bus.a_valid && bus.a_ready;
      tb_ = bus.b_valid && bus.b_ready;
      @(posedge clk);
      #1;
      if (ta) ia++;
      if (tb_) ib++;
      cyc++;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check("stream_done", 64'(ia == sa_addr.size() && ib == sb_addr.size()), 1);
  endtask

  task automatic drain();
    int c = 0;
    while ((bus.busy || exp_a.size() != 0 || exp_b.size() != 0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("drain_busy", 64'(bus.busy), 0);
    check("drain_a_left", 64'(exp_a.size()), 0);
    check("drain_b_left", 64'(exp_b.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_streams(input int na, input int a0, input int nb, input int b0);
    sa_addr.delete(); sa_data.delete(); sb_addr.delete(); sb_data.delete();
    for (int i = 0; i < na; i++) begin
      sa_addr.push_back(ADDR_W'(a0 + i));
      sa_data.push_back($urandom);
    end
    for (int i = 0; i < nb; i++) begin
      sb_addr.push_back(ADDR_W'(b0 + i));
      sb_data.push_back($urandom);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    // Reset with valids asserted
    idle_inputs();
    bus.q_addr  = 5'd7;
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h1111;
    bus.b_valid = 1'b1; bus.b_addr = 5'd23; bus.b_data = 32'h2222;
    #12;
    check("rst_rf_we", 64'(bus.rf_we), 0);
    check("rst_a_ready", 64'(bus.a_ready), 0);
    check("rst_b_ready", 64'(bus.b_ready), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_q_hit", 64'(bus.q_hit), 0);
    do_reset();
    @(negedge clk);
    check("rel_a_ready", 64'(bus.a_ready), 1);
    check("rel_b_ready", 64'(bus.b_ready), 1);
    @(negedge clk);
    check("rel_rf_we", 64'(bus.rf_we), 0);
    check("rel_busy", 64'(bus.busy), 0);

    // Single write: latency and lookup window
    do_reset();
    bus.q_addr  = 5'd5;
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    @(negedge clk);
    check("s_a_ready", 64'(bus.a_ready), 1);
    check("s_q_hit_pre", 64'(bus.q_hit), 0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    check("s_we_e1", 64'(bus.rf_we), 0);
    check("s_q_hit_q", 64'(bus.q_hit), 1);
    @(negedge clk);
    check("s_we_e2", 64'(bus.rf_we), 1);
    check("s_waddr", 64'(bus.rf_waddr), 5);
    check("s_wdata", 64'(bus.rf_wdata), 64'h1234);
    check("s_q_hit_fly", 64'(bus.q_hit), 1);
    @(negedge clk);
    check("s_we_drop", 64'(bus.rf_we), 0);
    check("s_q_hit_post", 64'(bus.q_hit), 0);
    check("s_busy_post", 64'(bus.busy), 0);
    drain();

    // Contention: strict alternation A,B,A,B...
    do_reset();
    load_streams(6, 1, 6, 16);
    run_streams(200);
    drain();
    check("c_writes", 64'(src_log.size()), 12);
    for (int i = 0; i < src_log.size(); i++)
      check($sformatf("c_src%0d", i), 64'(src_log[i]), 64'(i % 2));

    // Backpressure: A fills while B saturates
    do_reset();
    load_streams(3, 7, 6, 22);
    run_streams(200);
    check("bp_log_len", 64'(rdy_log.size() >= 4), 1);
    if (rdy_log.size() >= 4) begin
      check("bp_ready_1entry", 64'(rdy_log[2]), 1);
      check("bp_ready_full", 64'(rdy_log[3]), 0);
    end
    drain();

    // r0 write is consumed silently
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("r0_ready", 64'(bus.b_ready), 1);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("r0_we%0d", k), 64'(bus.rf_we), 0);
      check($sformatf("r0_busy%0d", k), 64'(bus.busy), 0);
    end

    // Flush with one write issuing and three queued
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1;  bus.a_data = 32'hA1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd17; bus.b_data = 32'hB1;
    @(posedge clk); #1;
    bus.a_addr = 5'd2;  bus.a_data = 32'hA2;
    bus.b_addr = 5'd18; bus.b_data = 32'hB2;
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.flush = 1'b1;
    bus.q_addr = 5'd17;
    @(negedge clk);
    check("f_we_issuing", 64'(bus.rf_we), 1);
    check("f_waddr", 64'(bus.rf_waddr), 1);
    check("f_a_ready", 64'(bus.a_ready), 0);
    check("f_b_ready", 64'(bus.b_ready), 0);
    check("f_q_hit_pre", 64'(bus.q_hit), 1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("f_we_after", 64'(bus.rf_we), 0);
    check("f_q_hit_b1", 64'(bus.q_hit), 0);
    check("f_busy", 64'(bus.busy), 0);
    bus.q_addr = 5'd2;
    #1;
    check("f_q_hit_a2", 64'(bus.q_hit), 0);
    repeat (4) @(negedge clk);
    drain();

    // Asynchronous reset mid-stream
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3;  bus.a_data = 32'hC3;
    bus.b_valid = 1'b1; bus.b_addr = 5'd19; bus.b_data = 32'hD3;
    @(posedge clk); #1;
    bus.a_addr = 5'd4;  bus.a_data = 32'hC4;
    bus.b_addr = 5'd20; bus.b_data = 32'hD4;
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.q_addr = 5'd19;
    @(negedge clk);
    check("r_we_before", 64'(bus.rf_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_we_async", 64'(bus.rf_we), 0);
    check("r_busy_async", 64'(bus.busy), 0);
    check("r_q_hit_async", 64'(bus.q_hit), 0);
    check("r_a_ready_async", 64'(bus.a_ready), 0);
    exp_a.delete();
    exp_b.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("r_we_post%0d", k), 64'(bus.rf_we), 0);
      check($sformatf("r_busy_post%0d", k), 64'(bus.busy), 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
